// File: rtl/fb_write_bridge_pkg.sv
// fb_bridge_pkg: shared types and defaults for the framebuffer write bridge
package fb_bridge_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_entry_t;
  localparam logic [31:0] FB_BASE_DEF = 32'h0000_1000;
  localparam logic [31:0] FB_BYTES_DEF = 32'h0000_1000;
  // 33-bit difference so addresses below base wrap far past any window size
  function automatic logic in_window(logic [31:0] a, logic [31:0] base, logic [31:0] bytes);
    return ({1'b0, a} - {1'b0, base}) < {1'b0, bytes};
  endfunction
endpackage

// File: rtl/fb_write_bridge_if.sv
// fb_write_bridge_if: CPU store, VGA fetch and RAM port bundle
interface fb_write_bridge_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] RD2;
  logic        END;
  logic        busy;
  logic        overflow;
  logic        vga_req;
  logic [31:0] vga_addr;
  logic        vga_gnt;
  logic [31:0] ReadData;
  logic        rdata_valid;
  logic [31:0] ADDRES;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        done;
  modport master (
    output MemWrite, ALUResult, RD2, END, vga_req, vga_addr, ram_rdata,
    input  busy, overflow, vga_gnt, ReadData, rdata_valid, ADDRES, ram_we, ram_wdata, done
  );
  modport slave (
    input  MemWrite, ALUResult, RD2, END, vga_req, vga_addr, ram_rdata,
    output busy, overflow, vga_gnt, ReadData, rdata_valid, ADDRES, ram_we, ram_wdata, done
  );
endinterface

// File: rtl/fb_write_bridge_fifo.sv
// fb_wr_fifo: fall-through store FIFO; a full FIFO still accepts a push when popped on the same edge
module fb_wr_fifo
  import fb_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wr_entry_t                din,
  output wr_entry_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wr_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fb_write_bridge.sv
// fb_write_bridge: buffers CPU stores and drains them into the framebuffer RAM around VGA fetches
module fb_write_bridge
  import fb_bridge_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] FB_BASE      = FB_BASE_DEF,
  parameter logic [31:0] FB_BYTES     = FB_BYTES_DEF,
  parameter int          STARVE_LIMIT = 16
) (
  input logic               CLOCK2_50,
  input logic               reset,
  fb_write_bridge_if.slave  bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t state;
  wr_entry_t head;
  logic full, empty, push, pop, force_wr, vga_win, rd_pend;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [SW-1:0] starve;
  assign force_wr = starve == SW'(STARVE_LIMIT) && !empty;
  assign vga_win = !force_wr && bus.vga_req;
  assign pop = !empty && !vga_win;
  assign push = state == RUN && bus.MemWrite && in_window(bus.ALUResult, FB_BASE, FB_BYTES);
  assign bus.busy = full;
  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLOCK2_50),
    .rst(reset),
    .push(push),
    .pop(pop),
    .din({bus.ALUResult, bus.RD2}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge CLOCK2_50) begin
    if (reset) begin
      bus.ADDRES <= '0;
      bus.ram_we <= 1'b0;
      bus.ram_wdata <= '0;
      bus.ReadData <= '0;
      bus.rdata_valid <= 1'b0;
      bus.vga_gnt <= 1'b0;
      bus.overflow <= 1'b0;
      bus.done <= 1'b0;
      starve <= '0;
      rd_pend <= 1'b0;
      state <= RUN;
    end else begin
      bus.ram_we <= pop;
      bus.vga_gnt <= vga_win;
      if (pop) begin
        bus.ADDRES <= head.addr;
        bus.ram_wdata <= head.data;
      end else if (vga_win) bus.ADDRES <= bus.vga_addr;
      starve <= (vga_win && !empty) ? starve + SW'(starve != SW'(STARVE_LIMIT)) : '0;
      // RAM returns data one edge after the grant; capture it on the next
      rd_pend <= bus.vga_gnt;
      bus.rdata_valid <= rd_pend;
      if (rd_pend) bus.ReadData <= bus.ram_rdata;
      if (push && full && !pop) bus.overflow <= 1'b1;
      if (state == FLUSH && count == '0) bus.done <= 1'b1;
      state <= (state == RUN && bus.END) ? FLUSH :
               (state == FLUSH && count == '0) ? DONE : state;
    end
  end
endmodule

// File: tb/tb_fb_write_bridge.sv
// tb_fb_write_bridge: directed stimulus with queue scoreboard for RAM writes and VGA reads
module tb_fb_write_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_we = -100;
  int nvalid = 0;
  typedef struct {
    logic [31:0] d;
    int          c;
  } rd_t;
  logic [63:0] wr_q[$];
  rd_t rd_q[$];

  always #5 clk = ~clk;

  fb_write_bridge_if bus();
  fb_write_bridge dut (.CLOCK2_50(clk), .reset(reset), .bus(bus));

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (!bus.ram_we)
      bus.ram_rdata <= (bus.ADDRES == 32'h1010) ? 32'h00FF_00FF : (32'hBAD0_0000 ^ bus.ADDRES);

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) rd_q.delete();
    else begin
      if (bus.ram_we) begin
        last_we = cyc;
        chk("gnt_during_write", {63'd0, bus.vga_gnt}, 64'd0);
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", bus.ADDRES, bus.ram_wdata);
        end else chk("ram_write", {bus.ADDRES, bus.ram_wdata}, wr_q.pop_front());
      end
      if (bus.vga_gnt) begin
        chk("vga_addr", {32'd0, bus.ADDRES}, 64'h1010);
        rd_q.push_back('{32'h00FF_00FF, cyc});
      end
      if (bus.rdata_valid) begin
        nvalid++;
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got data %h, required no valid", bus.ReadData);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          chk("read_data", {32'd0, bus.ReadData}, {32'd0, r.d});
          chk("read_latency", 64'(cyc - r.c), 64'd2);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d, bit exp);
    bus.MemWrite = 1'b1;
    bus.ALUResult = a;
    bus.RD2 = d;
    if (exp) wr_q.push_back({a, d});
    @(negedge clk);
    bus.MemWrite = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (wr_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, 64'(wr_q.size()), 64'd0);
  endtask

  task automatic chk_reset(string name);
    chk({name, "_bus"}, {bus.ADDRES, bus.ram_wdata}, 64'd0);
    chk({name, "_rdata"}, {32'd0, bus.ReadData}, 64'd0);
    chk({name, "_flags"}, {58'd0, bus.ram_we, bus.vga_gnt, bus.rdata_valid, bus.busy, bus.overflow, bus.done}, 64'd0);
  endtask

  initial begin
    int n;
    int v0;
    bus.MemWrite = 1'b0;
    bus.ALUResult = '0;
    bus.RD2 = '0;
    bus.END = 1'b0;
    bus.vga_req = 1'b0;
    bus.vga_addr = 32'h1010;
    tick(2);
    chk_reset("reset");
    reset = 1'b0;
    tick();
    // single store drains one edge after the push edge
    store(32'h1000, 32'hA5A5_0001, 1'b1);
    chk("t1_busy", {63'd0, bus.busy}, 64'd0);
    tick();
    chk("t1_we", {63'd0, bus.ram_we}, 64'd1);
    chk("t1_write", {bus.ADDRES, bus.ram_wdata}, {32'h1000, 32'hA5A5_0001});
    tick();
    chk("t1_we_off", {63'd0, bus.ram_we}, 64'd0);
    // window boundaries
    store(32'h2000, 32'h1111_1111, 1'b0);
    store(32'h0FFC, 32'h2222_2222, 1'b0);
    store(32'hFFFF_FFFC, 32'h3333_3333, 1'b0);
    tick(3);
    chk("t2_overflow", {63'd0, bus.overflow}, 64'd0);
    chk("t2_busy", {63'd0, bus.busy}, 64'd0);
    store(32'h1FFC, 32'h4444_4444, 1'b1);
    tick(2);
    chk("t2_last_in_window", 64'(wr_q.size()), 64'd0);
    // back-to-back VGA reads
    v0 = nvalid;
    bus.vga_req = 1'b1;
    tick(8);
    bus.vga_req = 1'b0;
    tick(4);
    chk("t3_valids", 64'(nvalid - v0), 64'd8);
    chk("t3_reads_left", 64'(rd_q.size()), 64'd0);
    // fill under VGA pressure, drop the 5th, then starvation forces a write
    bus.vga_req = 1'b1;
    tick(2);
    store(32'h1100, 32'hC000_0000, 1'b1);
    store(32'h1104, 32'hC000_0001, 1'b1);
    store(32'h1108, 32'hC000_0002, 1'b1);
    store(32'h110C, 32'hC000_0003, 1'b1);
    chk("t4_busy_full", {63'd0, bus.busy}, 64'd1);
    chk("t4_no_overflow_yet", {63'd0, bus.overflow}, 64'd0);
    store(32'h1110, 32'hC000_0004, 1'b0);
    chk("t4_busy_still", {63'd0, bus.busy}, 64'd1);
    chk("t4_overflow", {63'd0, bus.overflow}, 64'd1);
    n = 0;
    while (!bus.ram_we && n < 40) begin
      tick();
      n++;
    end
    chk("t4_force_delay", 64'(n), 64'd13);
    wait_drain("t4_drain");
    chk("t4_overflow_sticky", {63'd0, bus.overflow}, 64'd1);
    tick(2);
    // flush: push with END accepted, later stores ignored
    store(32'h1200, 32'hD000_0000, 1'b1);
    store(32'h1204, 32'hD000_0001, 1'b1);
    bus.END = 1'b1;
    store(32'h1208, 32'hD000_0002, 1'b1);
    bus.END = 1'b0;
    store(32'h120C, 32'hDEAD_0003, 1'b0);
    n = 0;
    while (!bus.done && n < 200) begin
      tick();
      n++;
    end
    chk("t5_done", {63'd0, bus.done}, 64'd1);
    chk("t5_done_gap", 64'(cyc - last_we), 64'd1);
    chk("t5_all_written", 64'(wr_q.size()), 64'd0);
    bus.END = 1'b1;
    store(32'h1210, 32'hDEAD_0004, 1'b0);
    bus.END = 1'b0;
    tick(5);
    chk("t5_done_sticky", {63'd0, bus.done}, 64'd1);
    chk("t5_vga_served", {63'd0, bus.vga_gnt}, 64'd1);
    // reset discards pending stores
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    chk("t6_done_cleared", {63'd0, bus.done}, 64'd0);
    store(32'h1300, 32'hEEEE_0000, 1'b0);
    store(32'h1304, 32'hEEEE_0001, 1'b0);
    reset = 1'b1;
    tick(2);
    chk_reset("t6_reset");
    reset = 1'b0;
    bus.vga_req = 1'b0;
    tick(20);
    chk("t6_no_write", {63'd0, bus.ram_we}, 64'd0);
    chk("t6_flags", {61'd0, bus.busy, bus.overflow, bus.done}, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end
endmodule
